// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA frame movers (mm2fifo reader, s2mm writer).
// Contents: read/write FSM state encoding, fixed AXI attribute encodings and
// small elaboration-time helpers for deriving AXI sizes from parameters.
package vdma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFstart,
    StAddr,
    StData,
    StDrain
  } vdma_state_e;

  localparam logic [1:0] AxiBurstIncr    = 2'b01;
  localparam logic [3:0] AxiCacheDefault = 4'b0010;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Bytes occupied by one pixel in memory, rounded up to 1, 2 or 4.
  function automatic int unsigned cupperbytes(input int unsigned bits);
    int unsigned b;
    b = (bits + 7) / 8;
    return (b > 2) ? 4 : b;
  endfunction

endpackage

// File: rtl/img_pos_cnt.sv
// Frame position counter shared by the VDMA readers and writers.
// col counts pixels remaining in the current row after the current word,
// row counts rows remaining after the current one. The word seen while both
// are zero is the last word of the frame; stepping there holds the count.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   load             start of frame: col <= width - Step, row <= height - 1
//   step             one data word consumed
//   width, height    frame geometry in pixels / rows
//   done             current word is the final word of the frame
module img_pos_cnt #(
  parameter int unsigned WBits = 12,
  parameter int unsigned HBits = 12,
  parameter int unsigned Step  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WBits-1:0] width,
  input  logic [HBits-1:0] height,
  output logic             done
);

  localparam logic [WBits-1:0] StepW = WBits'(Step);

  logic [WBits-1:0] col_q, col_d;
  logic [HBits-1:0] row_q, row_d;

  assign done = (col_q == '0) && (row_q == '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load) begin
      col_d = width - StepW;
      row_d = height - HBits'(1);
    end else if (step && !done) begin
      if (col_q == '0) begin
        col_d = width - StepW;
        row_d = row_q - HBits'(1);
      end else begin
        col_d = col_q - StepW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/mm2fifo.sv
// AXI4 burst-read master: fetches an img_width x img_height frame from
// base_addr in fixed-length bursts and pushes the beats straight into a FIFO.
// Ports:
//   M_AXI_ACLK/M_AXI_ARESETN  clock, async active-low reset
//   soft_resetn, resetting    soft stop request / stopping-or-reset status
//   img_width, img_height     frame geometry; base_addr sampled after frame_pulse
//   frame_pulse               one-cycle frame start strobe
//   dout, sof, wr_en, full    FIFO write side; burst_space = room for a burst
//   M_AXI_AR*, M_AXI_R*       AXI4 read address / read data channels
module mm2fifo
  import vdma_pkg::*;
#(
  parameter int unsigned C_M_AXI_BURST_LEN   = 16,
  parameter int unsigned C_M_AXI_ID_WIDTH    = 1,
  parameter int unsigned C_M_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH  = 32,
  parameter int unsigned C_IMG_WBITS         = 12,
  parameter int unsigned C_IMG_HBITS         = 12,
  parameter int unsigned C_PIXEL_WIDTH       = 8
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          soft_resetn,
  output logic                          resetting,
  input  logic [C_IMG_WBITS-1:0]        img_width,
  input  logic [C_IMG_HBITS-1:0]        img_height,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  output logic                          frame_pulse,
  output logic [C_M_AXI_DATA_WIDTH-1:0] dout,
  output logic                          sof,
  output logic                          wr_en,
  input  logic                          full,
  input  logic                          burst_space,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int unsigned PixelBytes  = cupperbytes(C_PIXEL_WIDTH);
  localparam int unsigned AdataPixels = C_M_AXI_DATA_WIDTH / 8 / PixelBytes;
  localparam int unsigned BurstBytes  = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;

  vdma_state_e                   state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic first_beat_q, first_beat_d;
  logic soft_resetting_q, soft_resetting_d;
  logic wait_space_q, wait_space_d;  // burst done, frame not done, FIFO lacks room
  logic rd_error_q, rd_error_d;
  logic pos_load, pos_step, pos_done;

  // RID is unchecked with a single outstanding burst; RRESP[0] only splits OKAY/EXOKAY.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_RID, M_AXI_RRESP[0]};

  img_pos_cnt #(
    .WBits(C_IMG_WBITS),
    .HBits(C_IMG_HBITS),
    .Step (AdataPixels)
  ) u_pos (
    .clk   (M_AXI_ACLK),
    .rst_n (M_AXI_ARESETN),
    .load  (pos_load),
    .step  (pos_step),
    .width (img_width),
    .height(img_height),
    .done  (pos_done)
  );

  always_comb begin
    state_d          = state_q;
    araddr_d         = araddr_q;
    first_beat_d     = first_beat_q;
    soft_resetting_d = soft_resetting_q;
    wait_space_d     = wait_space_q;
    rd_error_d       = rd_error_q;
    frame_pulse      = 1'b0;
    M_AXI_RREADY     = 1'b0;
    wr_en            = 1'b0;
    pos_load         = 1'b0;
    pos_step         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so frame_pulse reads 0 while reset is held.
        if (M_AXI_ARESETN && soft_resetn && burst_space) begin
          frame_pulse = 1'b1;
          rd_error_d  = 1'b0;
          state_d     = StFstart;
        end
      end
      StFstart: begin
        araddr_d     = base_addr;
        pos_load     = 1'b1;
        first_beat_d = 1'b1;
        state_d      = StAddr;
      end
      StAddr: begin
        if (!soft_resetn) soft_resetting_d = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = (soft_resetting_q || !soft_resetn) ? StDrain : StData;
        end
      end
      StData: begin
        if (wait_space_q) begin
          // No burst outstanding here, so a soft stop can go straight to idle.
          if (!soft_resetn) begin
            wait_space_d = 1'b0;
            state_d      = StIdle;
          end else if (burst_space) begin
            wait_space_d = 1'b0;
            state_d      = StAddr;
          end
        end else if (!soft_resetn) begin
          M_AXI_RREADY = 1'b1;
          if (M_AXI_RVALID && M_AXI_RLAST) begin
            state_d = StIdle;
          end else begin
            soft_resetting_d = 1'b1;
            state_d          = StDrain;
          end
        end else begin
          M_AXI_RREADY = ~full;
          wr_en        = M_AXI_RVALID & ~full;
          if (wr_en) begin
            pos_step     = 1'b1;
            first_beat_d = 1'b0;
            if (M_AXI_RRESP[1]) rd_error_d = 1'b1;
            if (M_AXI_RLAST) begin
              if (pos_done) begin
                state_d = StIdle;
              end else begin
                araddr_d = araddr_q + C_M_AXI_ADDR_WIDTH'(BurstBytes);
                if (burst_space) state_d = StAddr;
                else wait_space_d = 1'b1;
              end
            end
          end
        end
      end
      StDrain: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID && M_AXI_RLAST) begin
          soft_resetting_d = 1'b0;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q          <= StIdle;
      araddr_q         <= '0;
      first_beat_q     <= 1'b0;
      soft_resetting_q <= 1'b0;
      wait_space_q     <= 1'b0;
      rd_error_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      araddr_q         <= araddr_d;
      first_beat_q     <= first_beat_d;
      soft_resetting_q <= soft_resetting_d;
      wait_space_q     <= wait_space_d;
      rd_error_q       <= rd_error_d;
    end
  end

  assign resetting     = ~M_AXI_ARESETN | soft_resetting_q | ~soft_resetn;
  assign dout          = M_AXI_RDATA;
  assign sof           = first_beat_q & wr_en;
  assign M_AXI_ARVALID = (state_q == StAddr);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'(clogb2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_ARBURST = AxiBurstIncr;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = AxiCacheDefault;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;

endmodule

// File: tb/tb_mm2fifo.sv
// Directed bench for mm2fifo: 8x2 frame of 8-bit pixels, 32-bit data, 2-beat bursts.
module tb_mm2fifo;

  logic        M_AXI_ACLK;
  logic        M_AXI_ARESETN;
  logic        soft_resetn;
  logic        resetting;
  logic [11:0] img_width;
  logic [11:0] img_height;
  logic [31:0] base_addr;
  logic        frame_pulse;
  logic [31:0] dout;
  logic        sof;
  logic        wr_en;
  logic        full;
  logic        burst_space;
  logic [0:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARLOCK;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic [3:0]  M_AXI_ARQOS;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [0:0]  M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  mm2fifo #(
    .C_M_AXI_BURST_LEN (2),
    .C_M_AXI_ID_WIDTH  (1),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_IMG_WBITS       (12),
    .C_IMG_HBITS       (12),
    .C_PIXEL_WIDTH     (8)
  ) dut (
    .M_AXI_ACLK   (M_AXI_ACLK),
    .M_AXI_ARESETN(M_AXI_ARESETN),
    .soft_resetn  (soft_resetn),
    .resetting    (resetting),
    .img_width    (img_width),
    .img_height   (img_height),
    .base_addr    (base_addr),
    .frame_pulse  (frame_pulse),
    .dout         (dout),
    .sof          (sof),
    .wr_en        (wr_en),
    .full         (full),
    .burst_space  (burst_space),
    .M_AXI_ARID   (M_AXI_ARID),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARLEN  (M_AXI_ARLEN),
    .M_AXI_ARSIZE (M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARLOCK (M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARQOS  (M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID    (M_AXI_RID),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RLAST  (M_AXI_RLAST),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  initial M_AXI_ACLK = 1'b0;
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  int n_vec = 0;
  int n_bad = 0;
  int cycle_n = 0;
  int writes = 0;

  typedef struct {
    logic        bs;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [31:0] rdata;
    logic        fp;
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
    logic        wr_en;
    logic        sof;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and return the slave drivers to idle.
  task automatic cyc();
    @(negedge M_AXI_ACLK);
    cycle_n++;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RRESP   = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge M_AXI_ACLK);
    M_AXI_ARESETN = 1'b0;
    soft_resetn   = 1'b1;
    burst_space   = 1'b1;
    full          = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RDATA   = 32'h0;
    #1;
    chk("rst_resetting", resetting, 1);
    chk("rst_outputs", {frame_pulse, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, wr_en, sof}, 0);
    @(negedge M_AXI_ACLK);
    #1;
    burst_space   = 1'b0;
    M_AXI_ARESETN = 1'b1;
  endtask

  // Wait (bounded) for ARVALID, check the address, accept it on this cycle.
  task automatic wait_ar(input logic [31:0] exp_addr, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      cyc();
      #1;
      if (M_AXI_ARVALID) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL ar_timeout: no ARVALID within 8 cycles, expected ARADDR %0h", exp_addr);
    end else begin
      chk("araddr", M_AXI_ARADDR, exp_addr);
      M_AXI_ARREADY = 1'b1;
    end
  endtask

  // One 2-beat burst of words first_word, first_word+1.
  task automatic serve_burst(input logic [31:0] exp_addr, input int first_word,
                             input bit toggle_full, input bit drop_space, input int err_word);
    bit ok;
    int k;
    wait_ar(exp_addr, ok);
    if (!ok) return;
    if (drop_space) burst_space = 1'b0;
    k = 0;
    for (int t = 0; t < 12 && k < 2; t++) begin
      cyc();
      full         = toggle_full ? cycle_n[0] : 1'b0;
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = word(first_word + k);
      M_AXI_RLAST  = (k == 1);
      M_AXI_RRESP  = (first_word + k == err_word) ? 2'b10 : 2'b00;
      #1;
      chk("rready", M_AXI_RREADY, !full);
      chk("wr_en", wr_en, !full);
      if (!full) begin
        chk("dout", dout, word(first_word + k));
        chk("sof", sof, first_word + k == 0);
        writes++;
        k++;
      end
    end
    if (k < 2) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat_timeout: got %0d beats, expected 2", k);
    end
    full = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    M_AXI_ARESETN = 1'b0;
    soft_resetn   = 1'b1;
    img_width     = 12'd8;
    img_height    = 12'd2;
    base_addr     = 32'h1000;
    M_AXI_RID     = 1'b0;
    M_AXI_RDATA   = 32'h0;

    //        bs    ardy  rvld  rlast rdata    fp    arvld araddr       rrdy  wren  sof
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, word(0), 1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, word(1), 1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1008, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, word(2), 1'b0, 1'b0, 32'h1008, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, word(3), 1'b0, 1'b0, 32'h1008, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h1008, 1'b0, 1'b0, 1'b0};

    // Basic frame, cycle by cycle.
    do_reset();
    chk("ar_const", {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
                     M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS},
        {1'b0, 8'd1, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
    for (int i = 0; i < 9; i++) begin
      cyc();
      burst_space   = tbl[i].bs;
      M_AXI_ARREADY = tbl[i].arready;
      M_AXI_RVALID  = tbl[i].rvalid;
      M_AXI_RLAST   = tbl[i].rlast;
      M_AXI_RDATA   = tbl[i].rdata;
      #1;
      chk($sformatf("basic[%0d]", i),
          {frame_pulse, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, wr_en, sof, resetting, dout},
          {tbl[i].fp, tbl[i].arvalid, tbl[i].araddr, tbl[i].rready, tbl[i].wr_en, tbl[i].sof,
           1'b0, tbl[i].rdata});
    end

    // Backpressure: full toggles every cycle during data.
    do_reset();
    base_addr   = 32'h2000;
    burst_space = 1'b1;
    writes      = 0;
    serve_burst(32'h2000, 0, 1'b1, 1'b0, -1);
    serve_burst(32'h2008, 2, 1'b1, 1'b0, -1);
    chk("bp_writes", writes, 4);
    cyc();
    #1;
    chk("bp_next_fp", frame_pulse, 1);

    // Burst gating: no second AR until burst_space returns.
    do_reset();
    base_addr   = 32'h3000;
    burst_space = 1'b1;
    serve_burst(32'h3000, 0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("gate_arvalid", M_AXI_ARVALID, 0);
      chk("gate_rready", M_AXI_RREADY, 0);
    end
    burst_space = 1'b1;
    serve_burst(32'h3008, 2, 1'b0, 1'b0, -1);
    cyc();
    #1;
    chk("gate_next_fp", frame_pulse, 1);

    // Soft reset between beat 0 and beat 1, then drain.
    do_reset();
    base_addr   = 32'h4000;
    burst_space = 1'b1;
    wait_ar(32'h4000, ok);
    cyc();
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = word(0);
    #1;
    chk("sr_beat0_wr", wr_en, 1);
    cyc();
    soft_resetn = 1'b0;
    #1;
    chk("sr_fall", {resetting, M_AXI_RREADY, wr_en}, 3'b110);
    cyc();
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST  = 1'b1;
    M_AXI_RDATA  = word(1);
    #1;
    chk("sr_drain", {resetting, M_AXI_RREADY, wr_en}, 3'b110);
    cyc();
    #1;
    chk("sr_idle_held", {resetting, frame_pulse, M_AXI_ARVALID}, 3'b100);
    cyc();
    soft_resetn = 1'b1;
    #1;
    chk("sr_release", {resetting, frame_pulse}, 2'b01);
    // Soft reset in the same cycle as RLAST: straight to idle, no further AR.
    wait_ar(32'h4000, ok);
    cyc();
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = word(0);
    #1;
    chk("sr2_beat0_wr", wr_en, 1);
    cyc();
    soft_resetn  = 1'b0;
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST  = 1'b1;
    M_AXI_RDATA  = word(1);
    #1;
    chk("sr2_last", {M_AXI_RREADY, wr_en}, 2'b10);
    cyc();
    soft_resetn = 1'b1;
    #1;
    chk("sr2_idle", {M_AXI_ARVALID, frame_pulse, resetting}, 3'b010);

    // Async reset mid-data.
    do_reset();
    base_addr   = 32'h5000;
    burst_space = 1'b1;
    wait_ar(32'h5000, ok);
    cyc();
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = word(0);
    #1;
    chk("ar_beat0_wr", wr_en, 1);
    M_AXI_ARESETN = 1'b0;
    #1;
    chk("arst_now", {M_AXI_ARVALID, M_AXI_RREADY, wr_en, resetting, frame_pulse}, 5'b00010);
    burst_space = 1'b0;
    cyc();
    #1;
    M_AXI_ARESETN = 1'b1;
    cyc();
    burst_space = 1'b1;
    #1;
    chk("arst_idle_fp", {frame_pulse, M_AXI_ARVALID}, 2'b10);

    // SLVERR on word 1: still written, sticky error until next frame_pulse.
    do_reset();
    base_addr   = 32'h6000;
    burst_space = 1'b1;
    writes      = 0;
    serve_burst(32'h6000, 0, 1'b0, 1'b0, 1);
    cyc();
    #1;
    chk("err_set", dut.rd_error_q, 1);
    serve_burst(32'h6008, 2, 1'b0, 1'b0, -1);
    chk("err_writes", writes, 4);
    cyc();
    #1;
    chk("err_fp", {frame_pulse, dut.rd_error_q}, 2'b11);
    cyc();
    #1;
    chk("err_cleared", dut.rd_error_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
